// File: rtl/pattern_match_pkg.sv
// Purpose : shared types for the serial pattern-match run controller.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state encoding, run-end status codes and the status width.
package pattern_match_pkg;

   localparam int STATUS_W = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_e;

   typedef enum logic [STATUS_W-1:0] {
      ST_LIMIT   = 2'd0,
      ST_ABORT   = 2'd1,
      ST_BADCFG  = 2'd2,
      ST_TIMEOUT = 2'd3
   } status_e;

endpackage

// File: rtl/pattern_shift_match.sv
// Purpose : shift buffer, fill counter and length-masked compare for the matcher.
// Latency : hit is combinational on the beat being shifted; state updates on clk.
// Backpressure: none; a beat is taken whenever shift is high.
// Ports:
//   clk, rst            clock, async active-high reset
//   clear               zero buffer and fill (wins over shift)
//   shift, din          consume one serial bit
//   len, pattern        active length and pattern (bit [len-1] first on the wire)
//   hit                 the bit on din, if shifted now, completes a match
module pattern_shift_match
   import pattern_match_pkg::*;
#(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               shift,
   input  logic               din,
   input  logic [LEN_W-1:0]   len,
   input  logic [MAX_LEN-1:0] pattern,
   output logic               hit
);

   logic [MAX_LEN-1:0] buf_q, buf_d;
   logic [LEN_W-1:0]   fill_q, fill_d;
   logic [MAX_LEN-1:0] buf_nxt;
   logic [MAX_LEN-1:0] mask;
   logic [LEN_W:0]     fill_inc;
   logic               full_nxt;

   assign buf_nxt  = {buf_q[MAX_LEN-2:0], din};
   assign fill_inc = {1'b0, fill_q} + (LEN_W+1)'(1);
   assign full_nxt = (fill_inc >= {1'b0, len});

   // Only the low len bits of buffer and pattern take part in the compare.
   always_comb begin
      mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         mask[i] = (i < int'(len));
      end
   end

   // Evaluated as if din were shifted this cycle; the caller gates it with its beat.
   assign hit = full_nxt && (((buf_nxt ^ pattern) & mask) == '0);

   always_comb begin
      buf_d  = buf_q;
      fill_d = fill_q;
      if (clear) begin
         buf_d  = '0;
         fill_d = '0;
      end else if (shift) begin
         buf_d  = buf_nxt;
         fill_d = full_nxt ? len : fill_inc[LEN_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_q  <= '0;
         fill_q <= '0;
      end else begin
         buf_q  <= buf_d;
         fill_q <= fill_d;
      end
   end

endmodule

// File: rtl/pattern_match_ctrl.sv
// Purpose : run controller for a programmable MSB-first serial pattern matcher.
// Latency : match/match_count update one cycle after the completing beat; done one cycle after the end event.
// Backpressure: none; every din_valid beat in RUN is consumed, beats outside RUN are dropped.
// Ports:
//   clk, reset                       clock, async active-high reset
//   start, abort                     run control (start sampled in IDLE only)
//   cfg_pattern/len/overlap/limit    configuration, latched on an accepted start
//   din, din_valid                   serial input beat
//   busy, match, match_count, done, status   run outputs
// Optional feature: define PATTERN_MATCH_TIMEOUT_EN to end a run after
// TIMEOUT_CYCLES consecutive cycles in RUN without a beat (status TIMEOUT).
module pattern_match_ctrl
   import pattern_match_pkg::*;
#(
   parameter  int MAX_LEN        = 8,
   parameter  int CNT_W          = 16,
   parameter  int TIMEOUT_CYCLES = 1024,
   localparam int LEN_W          = $clog2(MAX_LEN + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                abort,
   input  logic [MAX_LEN-1:0]  cfg_pattern,
   input  logic [LEN_W-1:0]    cfg_len,
   input  logic                cfg_overlap,
   input  logic [CNT_W-1:0]    cfg_limit,
   input  logic                din,
   input  logic                din_valid,
   output logic                busy,
   output logic                match,
   output logic [CNT_W-1:0]    match_count,
   output logic                done,
   output logic [STATUS_W-1:0] status
);

   state_e             state_q, state_d;
   status_e            status_q, status_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               match_q, match_d;
   logic [MAX_LEN-1:0] pat_q, pat_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               ovl_q, ovl_d;
   logic [CNT_W-1:0]   lim_q, lim_d;

   logic               shift;
   logic               clear;
   logic               hit;
   logic               beat_hit;
   logic               timeout;
   logic [CNT_W-1:0]   cnt_inc;
   logic               len_ok;

   // Abort suppresses the beat entirely: it is neither shifted nor counted.
   assign shift    = (state_q == RUN) && din_valid && !abort;
   assign beat_hit = shift && hit;
   // Non-overlapping mode restarts the history after each match.
   assign clear    = (state_q == ARM) || (beat_hit && !ovl_q);
   assign cnt_inc  = (count_q == '1) ? count_q : count_q + CNT_W'(1);
   assign len_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));

   pattern_shift_match #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W)
   ) u_shift (
      .clk     (clk),
      .rst     (reset),
      .clear   (clear),
      .shift   (shift),
      .din     (din),
      .len     (len_q),
      .pattern (pat_q),
      .hit     (hit)
   );

`ifdef PATTERN_MATCH_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] idle_q, idle_d;

   // Counts consecutive beat-less cycles in RUN; zero everywhere else, so it
   // starts clean on every entry to RUN.
   always_comb begin
      idle_d  = '0;
      timeout = 1'b0;
      if (state_q == RUN && !din_valid) begin
         idle_d  = idle_q + TO_W'(1);
         timeout = (idle_d == TO_W'(TIMEOUT_CYCLES));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) idle_q <= '0;
      else       idle_q <= idle_d;
   end
`else
   // Feature compiled out; the parameter is referenced only so overriding it stays legal.
   assign timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

   always_comb begin
      state_d  = state_q;
      status_d = status_q;
      count_d  = count_q;
      match_d  = 1'b0;
      pat_d    = pat_q;
      len_d    = len_q;
      ovl_d    = ovl_q;
      lim_d    = lim_q;
      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               pat_d    = cfg_pattern;
               len_d    = cfg_len;
               ovl_d    = cfg_overlap;
               lim_d    = cfg_limit;
               count_d  = '0;
               status_d = ST_LIMIT;
               if (len_ok) begin
                  state_d = ARM;
               end else begin
                  state_d  = DONE;
                  status_d = ST_BADCFG;
               end
            end
         end
         ARM: begin
            if (abort) begin
               state_d  = DONE;
               status_d = ST_ABORT;
            end else begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (abort) begin
               state_d  = DONE;
               status_d = ST_ABORT;
            end else if (beat_hit) begin
               match_d = 1'b1;
               count_d = cnt_inc;
               if (lim_q != '0 && cnt_inc == lim_q) begin
                  state_d  = DONE;
                  status_d = ST_LIMIT;
               end
            end else if (timeout) begin
               state_d  = DONE;
               status_d = ST_TIMEOUT;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         status_q <= ST_LIMIT;
         count_q  <= '0;
         match_q  <= 1'b0;
         pat_q    <= '0;
         len_q    <= '0;
         ovl_q    <= 1'b0;
         lim_q    <= '0;
      end else begin
         state_q  <= state_d;
         status_q <= status_d;
         count_q  <= count_d;
         match_q  <= match_d;
         pat_q    <= pat_d;
         len_q    <= len_d;
         ovl_q    <= ovl_d;
         lim_q    <= lim_d;
      end
   end

   // done is decoded from the one-cycle DONE state, so a limit-ending match
   // pulse and the done pulse land in the same cycle.
   assign busy        = (state_q == ARM) || (state_q == RUN);
   assign done        = (state_q == DONE);
   assign match       = match_q;
   assign match_count = count_q;
   assign status      = status_q;

endmodule

// File: doc/pattern_match_ctrl.md
Name: pattern_match_ctrl

Overview:
- Run controller for a programmable serial pattern matcher (1–MAX_LEN bit pattern, MSB-first) on a 1-bit input stream.
- Latches a configuration on start, clears the match history, then counts matches until a limit, abort or error, and reports a status code.
- Sits between a register/config interface and the serial bit source; feeds match pulses and counts to downstream logic.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (≥2).
- CNT_W, 16, width of the match limit and match counter.
- TIMEOUT_CYCLES, 1024, idle-beat timeout in RUN; used only with the optional feature.
- LEN_W, $clog2(MAX_LEN+1), derived localparam; width of cfg_len.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE.
- abort  in  1  terminate the current run.
- cfg_pattern  in  MAX_LEN  pattern; bit [cfg_len-1] is the first bit expected.
- cfg_len  in  LEN_W  pattern length; legal range 1..MAX_LEN.
- cfg_overlap  in  1  1: overlapping matches count; 0: history cleared after each match.
- cfg_limit  in  CNT_W  stop after this many matches; 0 = unlimited.
- din  in  1  serial data bit.
- din_valid  in  1  din is a valid beat this cycle.
- busy  out  1  high in ARM and RUN.
- match  out  1  one-cycle pulse per detected match.
- match_count  out  CNT_W  matches in the current or last run.
- done  out  1  one-cycle pulse when a run ends.
- status  out  2  end reason: 0 LIMIT, 1 ABORT, 2 BADCFG, 3 TIMEOUT.

Behaviour:
- Reset (async): state IDLE; busy, match, done = 0; match_count = 0; status = 0; shift buffer and fill counter = 0.
- FSM states: IDLE, ARM, RUN, DONE.
- IDLE:
  - start=1 latches all cfg_* inputs and clears match_count.
  - Next state is ARM if cfg_len is in 1..MAX_LEN; otherwise DONE with status BADCFG.
  - abort=1 in the same cycle as start: start is ignored and the FSM stays in IDLE.
- ARM: one cycle. Clears the shift buffer and fill counter. Next state RUN. Beats in ARM are ignored.
- RUN, per din_valid beat:
  - Shift buffer <= {buffer, din}.
  - fill <= min(fill+1, len).
  - Match condition: fill+1 ≥ len and the new buffer[len-1:0] == pattern[len-1:0].
  - match is registered and pulses the cycle after the completing beat.
  - match_count increments in that same cycle and saturates at all-ones.
  - cfg_overlap=0: on a match, buffer and fill are cleared instead of updated.
  - cfg_limit≠0 and the incremented count == cfg_limit: next state DONE, status LIMIT. The match pulse and the done pulse occur in the same cycle.
  - Bits outside [len-1:0] are don't-care for the compare.
- abort in ARM or RUN: next state DONE, status ABORT. Abort wins over a beat or match in the same cycle; that beat is not consumed or counted.
- abort in IDLE or DONE has no effect.
- DONE: done=1 for exactly one cycle, then IDLE. status and match_count hold until the next accepted start.
- start while busy or in DONE: ignored.
- Reset mid-run: immediate return to IDLE; the count is lost; no done pulse.

Optional Feature:
- Macro: PATTERN_MATCH_TIMEOUT_EN.
- Defined:
  - An idle counter runs in RUN. It resets on each din_valid and is cleared on entry to RUN.
  - When it reaches TIMEOUT_CYCLES, next state is DONE with status TIMEOUT. Abort has priority.
- Undefined: no counter is instantiated; status 3 is never produced; the TIMEOUT_CYCLES value is ignored.

Decomposition:
- Package pattern_match_pkg:
  - state enum (IDLE, ARM, RUN, DONE).
  - status enum (ST_LIMIT, ST_ABORT, ST_BADCFG, ST_TIMEOUT).
  - 2-bit status width constant.
- Sub-module pattern_shift_match (datapath):
  - Contains the shift buffer, fill counter and masked compare.
  - Inputs: clear, shift, din, len, pattern.
  - Output: combinational hit.
- The controller owns the FSM, counters, overlap handling and outputs.

Test Plan:
- pattern=4'b1010, len=4, overlap=1, limit=0; beats 1,0,1,0,1,0 → match pulses after beats 4 and 6; match_count=2; abort → done with status=1.
- Same stream, overlap=0 → single match after beat 4; a second match only after 4 more beats 1,0,1,0; count=2.
- len=3, pattern=3'b111, limit=2; stream of eight 1s with overlap=1 → matches after beats 3 and 4; done coincides with the second match pulse; status=0; busy low the next cycle; later beats ignored.
- cfg_len=0 or cfg_len=MAX_LEN+1 → done 1 cycle after start; status=2; match_count=0; busy never asserted.
- Mid-run with fill=3 of 4, assert reset for 1 cycle → IDLE immediately; no done; a new start followed by 0,1,0 does not match.
- PATTERN_MATCH_TIMEOUT_EN defined, TIMEOUT_CYCLES=16; RUN with no din_valid for 16 cycles → done with status=3. Repeat with the macro undefined → stays in RUN.
